// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: byte-serial add/subtract sequencer driving a shared external
// 8-bit carry-lookahead adder. A multi-byte operation takes NBYTES RUN cycles.
// The carry ripples between bytes through a local carry register.
// Optional feature macro: CLA_SEQ_SUB_EN. When it is defined, the sub input
// selects A minus B. When it is undefined, the sub input is ignored.
module cla_seq_ctrl #(
   parameter int unsigned NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [8*NBYTES-1:0] opa,
   input  logic [8*NBYTES-1:0] opb,
   input  logic                cin,
   input  logic                sub,
   output logic                busy,
   output logic                done,
   output logic [8*NBYTES-1:0] result,
   output logic                cout,
   output logic                ovf,
   output logic [7:0]          adder_a,
   output logic [7:0]          adder_b,
   output logic                adder_cin,
   input  logic [7:0]          adder_sum,
   input  logic                adder_cout
);

   localparam int unsigned W  = 8 * NBYTES;
   localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   logic [1:0]    state;
   logic [IW-1:0] idx;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic          sub_q;
   logic          carry;
   logic [W-1:0]  result_q;
   logic          cout_q;
   logic          ovf_q;
   logic          sub_en;
   logic [IW+2:0] bofs;
   logic [7:0]    b_byte;

`ifdef CLA_SEQ_SUB_EN
   assign sub_en = sub;
`else
   logic unused_sub;
   assign unused_sub = sub;
   assign sub_en     = 1'b0;
`endif

   // The bit offset of the current byte is the byte index times 8.
   assign bofs = {idx, 3'b000};

   assign busy   = (state != S_IDLE);
   assign done   = (state == S_DONE);
   assign result = result_q;
   assign cout   = cout_q;
   assign ovf    = ovf_q;

   // Drive the current byte slice to the shared adder, but only during RUN.
   always_comb begin
      adder_a   = '0;
      adder_b   = '0;
      adder_cin = 1'b0;
      b_byte    = b_q[bofs +: 8];
      if (state == S_RUN) begin
         adder_a   = a_q[bofs +: 8];
         adder_b   = sub_q ? ~b_byte : b_byte;
         adder_cin = carry;
      end
   end

   // Sequencer: capture on accept, accumulate one byte per RUN edge, pulse DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         idx      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         sub_q    <= 1'b0;
         carry    <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_q   <= opa;
                  b_q   <= opb;
                  sub_q <= sub_en;
                  carry <= sub_en ? 1'b1 : cin;
                  idx   <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               result_q[bofs +: 8] <= adder_sum;
               carry               <= adder_cout;
               if (idx == LAST) begin
                  // The sign of the effective B is the raw msb flipped when subtracting.
                  cout_q <= adder_cout;
                  ovf_q  <= (a_q[W-1] == (b_q[W-1] ^ sub_q)) &&
                            (adder_sum[7] != a_q[W-1]);
                  idx    <= '0;
                  state  <= S_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// tb_cla_seq_ctrl: directed bench for cla_seq_ctrl with NBYTES=4, including a
// behavioural model of the external 8-bit adder.
module tb_cla_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] opa, opb;
   logic        cin, sub;
   logic        busy, done;
   logic [31:0] result;
   logic        cout, ovf;
   logic [7:0]  adder_a, adder_b, adder_sum;
   logic        adder_cin, adder_cout;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] opa;
      logic [31:0] opb;
      logic        cin;
      logic        sub;
      logic [31:0] res;
      logic        co;
      logic        ov;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   // External shared 8-bit adder, combinational.
   always_comb {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {8'b0, adder_cin};

   cla_seq_ctrl #(.NBYTES(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .opa        (opa),
      .opb        (opb),
      .cin        (cin),
      .sub        (sub),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .cout       (cout),
      .ovf        (ovf),
      .adder_a    (adder_a),
      .adder_b    (adder_b),
      .adder_cin  (adder_cin),
      .adder_sum  (adder_sum),
      .adder_cout (adder_cout)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One full operation from an idle negedge; operands are scrambled after accept.
   task automatic run_op(input vec_t v, input int n);
      int cyc;
      @(negedge clk);
      opa = v.opa; opb = v.opb; cin = v.cin; sub = v.sub; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      opa = ~v.opa; opb = ~v.opb; cin = ~v.cin; sub = ~v.sub;
      cyc = 1;
      chk($sformatf("v%0d_busy_run", n), 64'(busy), 64'(1));
      while (done !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk($sformatf("v%0d_latency", n), 64'(cyc), 64'(5));
      chk($sformatf("v%0d_result", n), 64'(result), 64'(v.res));
      chk($sformatf("v%0d_cout", n), 64'(cout), 64'(v.co));
      chk($sformatf("v%0d_ovf", n), 64'(ovf), 64'(v.ov));
      chk($sformatf("v%0d_adder_a_done", n), 64'(adder_a), 64'(0));
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", n), 64'(done), 64'(0));
      chk($sformatf("v%0d_busy_idle", n), 64'(busy), 64'(0));
      chk($sformatf("v%0d_result_hold", n), 64'(result), 64'(v.res));
   endtask

   initial begin
      int ndone;
      vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
      vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
`ifdef CLA_SEQ_SUB_EN
      vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
`else
      vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0};
`endif
      vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      vecs[5] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0};

      rst_n = 1'b0; start = 1'b0; opa = '0; opb = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_result", 64'(result), 64'(0));
      chk("rst_cout", 64'(cout), 64'(0));
      chk("rst_ovf", 64'(ovf), 64'(0));
      chk("rst_adder", 64'({adder_a, adder_b, adder_cin}), 64'(0));
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) run_op(vecs[i], i);

      // start held high: accepts at cycles 0 and 6, done at 5 and 11.
      @(negedge clk);
      opa = 32'h0000_0001; opb = 32'h0000_0002; cin = 1'b0; sub = 1'b0; start = 1'b1;
      ndone = 0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            chk("held_adder_a_k0", 64'(adder_a), 64'(8'h01));
            chk("held_adder_b_k0", 64'(adder_b), 64'(8'h02));
            chk("held_adder_cin_k0", 64'(adder_cin), 64'(0));
         end
         if (cyc == 2) begin
            opa = 32'h0000_0010; opb = 32'h0000_0020;
         end
         if (cyc == 6) chk("held_idle_c6", 64'(busy), 64'(0));
         if (cyc == 7) chk("held_busy_c7", 64'(busy), 64'(1));
         if (done === 1'b1) begin
            ndone++;
            if (cyc == 5) chk("held_res1", 64'(result), 64'h3);
            else if (cyc == 11) chk("held_res2", 64'(result), 64'h30);
            else chk("held_done_cycle", 64'(cyc), 64'(5));
         end
         if (cyc == 11) start = 1'b0;
      end
      chk("held_done_count", 64'(ndone), 64'(2));

      // Reset in the second RUN cycle aborts; start is ignored while in reset.
      @(negedge clk);
      opa = 32'h1111_1111; opb = 32'h2222_2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0; start = 1'b1;
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_done", 64'(done), 64'(0));
      chk("abort_result", 64'(result), 64'(0));
      chk("abort_cout_ovf", 64'({cout, ovf}), 64'(0));
      @(negedge clk);
      chk("rst_ignores_start", 64'(busy), 64'(0));
      rst_n = 1'b1; start = 1'b0;
      ndone = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) ndone++;
      end
      chk("abort_no_done", 64'(ndone), 64'(0));
      run_op(vecs[5], 6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
